// File: rtl/accel_sequencer.sv
// accel_sequencer -- micro-program sequencer for the TinyQV accelerator
// peripheral. The host loads up to PROG_DEPTH instructions through the byte
// register interface and writes start; the block then fetches and executes
// each instruction on the four 8-bit working registers A-D on its own.
//
// Ports:
//   clk        project clock
//   rst_n      asynchronous active-low reset (aborts a run immediately)
//   ui_in      input PMOD, unused
//   uo_out     [7]=busy, [6]=done, [5:0]=0
//   address    register map address
//   data_write write strobe, data_in valid
//   data_in    write data
//   data_out   read data, combinational from address
//
// Register map: 0-3 A-D, 4 staged op, 5 commit slot / program count,
//   6 control (bit0 start, bit1 clear program, bit2 clear done) / status
//   {busy, done, ovf, 0, PC[3:0]}, 7-15 read as 0.
//
// Optional feature: define LOOP_EN to turn op 10 into DJNZ (decrement D,
// jump to {b,a} while D is non-zero). Without it op 10 is a NOP.
module accel_sequencer #(
  parameter int PROG_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int CW = $clog2(PROG_DEPTH) + 1;  // PC / count width
  localparam int AW = $clog2(PROG_DEPTH);      // slot index width
  localparam logic [CW-1:0] FULL = CW'(PROG_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;

  state_t        state, state_next;
  logic [7:0]    regs [4];
  logic [9:0]    prog [PROG_DEPTH];  // {op[3:0], dest, b, a}
  logic [9:0]    ir;
  logic [CW-1:0] count, pc, pc_next, pc_inc;
  logic [3:0]    staged_op;
  logic          done, ovf, busy;
  logic          start_go, finish, wr_en;
  logic [1:0]    wr_dest;
  logic [7:0]    wr_val, va, vb;
  logic [3:0]    op;

  logic unused_inputs;
  assign unused_inputs = ^ui_in;

  assign busy   = (state != S_IDLE);
  assign uo_out = {busy, done, 6'b0};
  assign op     = ir[9:6];
  assign va     = regs[ir[1:0]];
  assign vb     = regs[ir[3:2]];
  assign pc_inc = pc + CW'(1);

  // A real run starts only for a non-empty program with no clear in the
  // same write; clear+start behaves as starting an empty program.
  assign start_go = data_write && (address == 4'd6) && data_in[0] &&
                    !data_in[1] && (count != '0) && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_dest    = ir[5:4];
    wr_val     = 8'h00;
    pc_next    = pc_inc;
    finish     = 1'b0;
    case (state)
      S_IDLE:  if (start_go) state_next = S_FETCH;
      S_FETCH: state_next = S_EXEC;
      S_EXEC: begin
        finish = (pc_inc == count);
        case (op)
          4'd1: begin wr_en = 1'b1; wr_val = va + vb;         end
          4'd2: begin wr_en = 1'b1; wr_val = va - vb;         end
          4'd3: begin wr_en = 1'b1; wr_val = va & vb;         end
          4'd4: begin wr_en = 1'b1; wr_val = va | vb;         end
          4'd5: begin wr_en = 1'b1; wr_val = va ^ vb;         end
          4'd6: begin wr_en = 1'b1; wr_val = {va[6:0], 1'b0}; end
          4'd7: begin wr_en = 1'b1; wr_val = {1'b0, va[7:1]}; end
          4'd8: begin wr_en = 1'b1; wr_val = va;              end
          4'd9: finish = 1'b1;
`ifdef LOOP_EN
          4'd10: begin
            wr_en   = 1'b1;
            wr_dest = 2'd3;
            wr_val  = regs[3] - 8'd1;
            if (wr_val != 8'h00) begin
              // Target is {b,a} masked to the PC width; out of range ends.
              pc_next = CW'(ir[3:0]);
              finish  = (pc_next >= count);
            end
          end
`endif
          default: ;
        endcase
        state_next = finish ? S_IDLE : S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      for (int i = 0; i < PROG_DEPTH; i++) prog[i] <= 10'h000;
      ir        <= 10'h000;
      count     <= '0;
      pc        <= '0;
      staged_op <= 4'h0;
      done      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (state == S_FETCH) ir <= prog[pc[AW-1:0]];
      if (state == S_EXEC) begin
        if (wr_en) regs[wr_dest] <= wr_val;
        pc <= pc_next;
        if (finish) done <= 1'b1;
      end
      if (data_write) begin
        case (address)
          4'd0, 4'd1, 4'd2, 4'd3: if (!busy) regs[address[1:0]] <= data_in;
          4'd4: staged_op <= data_in[3:0];
          4'd5: if (!busy) begin
            if (count == FULL) ovf <= 1'b1;
            else begin
              prog[count[AW-1:0]] <= {staged_op, data_in[5:0]};
              count <= count + CW'(1);
            end
          end
          4'd6: begin
            if (data_in[2]) done <= 1'b0;
            // Program clear is held off during a run so the end-of-program
            // compare always sees the count the run started with.
            if (!busy) begin
              if (data_in[1]) begin
                count <= '0;
                ovf   <= 1'b0;
              end
              if (data_in[0]) begin
                if (start_go) begin
                  done <= 1'b0;
                  pc   <= '0;
                end else begin
                  done <= 1'b1;  // empty program completes at once
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      4'd0, 4'd1, 4'd2, 4'd3: data_out = regs[address[1:0]];
      4'd4: data_out = {4'b0, staged_op};
      4'd5: data_out = 8'(count);
      4'd6: data_out = {busy, done, ovf, 1'b0, 4'(pc)};
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_accel_sequencer.sv
// Directed bench for accel_sequencer: expected register reads are queued as
// stimulus is applied and checked once the run completes.
module tb_accel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int tests  = 0;
  int failed = 0;
  int cyc;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] val;
    string      tag;
  } exp_t;
  exp_t sb[$];

  accel_sequencer #(.PROG_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_write(data_write), .data_in(data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
    $display("[TB] write addr=%0d data=%02h", a, d);
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] v, input string tag);
    exp_t e;
    e.addr = a; e.val = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      address = e.addr;
      #1;
      $display("[TB] read %s addr=%0d data=%02h", e.tag, e.addr, data_out);
      chk(e.tag, data_out, e.val);
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (uo_out[7] && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("run_timeout", {7'b0, uo_out[7]}, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; ui_in = 8'h00; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_uo_out", uo_out, 8'h00);
    for (int i = 0; i < 8; i++) push(4'(i), 8'h00, "rst_reg");
    drain();

    // ADD C=A+B, SUB D=A-B
    wr(0, 8'h05); wr(1, 8'h03);
    wr(4, 8'h01); wr(5, 8'h24);
    wr(4, 8'h02); wr(5, 8'h34);
    push(2, 8'h08, "add_c"); push(3, 8'h02, "sub_d");
    push(6, 8'h42, "status1"); push(5, 8'h02, "count1");
    wr(6, 8'h01);
    wait_done(cyc);
    chk("busy_cycles1", 8'(cyc), 8'd4);
    chk("uo_done1", uo_out, 8'h40);
    drain();

    // Wrapping ADD and SHL1
    wr(6, 8'h06);
    wr(0, 8'hFF); wr(1, 8'h02);
    wr(4, 8'h01); wr(5, 8'h04);
    wr(4, 8'h06); wr(5, 8'h11);
    push(0, 8'h01, "add_wrap"); push(1, 8'h04, "shl1");
    wr(6, 8'h01);
    wait_done(cyc);
    chk("busy_cycles2", 8'(cyc), 8'd4);
    drain();

    // Overflow, clear, empty start
    wr(6, 8'h06);
    for (int i = 0; i < 9; i++) wr(5, 8'h00);
    push(5, 8'h08, "ovf_count"); push(6, 8'h22, "ovf_status");
    drain();
    wr(6, 8'h02);
    push(5, 8'h00, "clr_count"); push(6, 8'h02, "clr_status");
    drain();
    wr(6, 8'h01);
    chk("empty_uo", uo_out, 8'h40);
    wait_done(cyc);
    chk("empty_busy", 8'(cyc), 8'd0);

    // Writes during a run are ignored; HALT stops early
    wr(0, 8'h11); wr(1, 8'h22);
    wr(6, 8'h06);
    wr(4, 8'h00); wr(5, 8'h00);
    wr(4, 8'h09); wr(5, 8'h00);
    wr(4, 8'h08); wr(5, 8'h01);
    wr(6, 8'h01);
    wr(0, 8'hAA); wr(6, 8'h01); wr(5, 8'h3F);
    push(0, 8'h11, "busy_a"); push(1, 8'h22, "busy_b");
    push(5, 8'h03, "busy_count"); push(6, 8'h42, "halt_status");
    wait_done(cyc);
    chk("halt_tail", 8'(cyc), 8'd1);
    drain();

    // Asynchronous reset in the EXEC cycle
    wr(0, 8'h5A);
    wr(6, 8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_uo", uo_out, 8'h00);
    address = 4'd0; #1; chk("arst_a", data_out, 8'h00);
    address = 4'd5; #1; chk("arst_count", data_out, 8'h00);
    address = 4'd6; #1; chk("arst_status", data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef LOOP_EN
    // DJNZ loop: three passes of A += B
    wr(0, 8'h00); wr(1, 8'h01); wr(3, 8'h03);
    wr(4, 8'h01); wr(5, 8'h04);
    wr(4, 8'h0A); wr(5, 8'h00);
    push(0, 8'h03, "djnz_a"); push(3, 8'h00, "djnz_d");
    wr(6, 8'h01);
    wait_done(cyc);
    chk("djnz_cycles", 8'(cyc), 8'd12);
    chk("djnz_uo", uo_out, 8'h40);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/accel_sequencer.md
Name: accel_sequencer

Overview:
Micro-program sequencer for the TinyQV accelerator peripheral's four 8-bit working registers A–D.
- Host loads a short instruction list through the peripheral byte interface, then writes start.
- The block fetches each instruction and executes it on A–D (op, dest, src a, src b) with no further host involvement.
- Busy/done status is reported on the register map and the output PMOD.

Parameters:
PROG_DEPTH, 8, number of instruction slots (power of 2, 2..16); PC/count width = clog2(PROG_DEPTH)+1

Ports:
clk  in  1  clock (TinyQV project clock, 64 MHz nominal)
rst_n  in  1  reset, asynchronous, active-low
ui_in  in  8  input PMOD; unused
uo_out  out  8  [7]=busy, [6]=done, [5:0]=0
address  in  4  register address
data_write  in  1  write strobe, data_in valid
data_in  in  8  write data
data_out  out  8  read data, combinational from address

Behaviour:
- Reset (async, rst_n=0): A–D=0, program count=0, PC=0, staged op=0, state IDLE, busy=0, done=0, ovf=0, uo_out=0, and all program slots=0. Reset mid-run aborts immediately.
- Map writes:
  - 0–3: A–D; ignored while busy.
  - 4: stage op=data_in[3:0].
  - 5: commit {op, dest=data_in[5:4], b=data_in[3:2], a=data_in[1:0]} to slot[count]; count++. Ignored while busy. When count==PROG_DEPTH the write is dropped and ovf sets (sticky).
  - 6: control. bit0 start, bit1 clear program (count=0, ovf=0), bit2 clear done. Start is ignored while busy. If bit1 and bit0 are both set, clear takes precedence and start is treated as an empty program.
- Map reads:
  - 0–3: A–D.
  - 4: {4'b0, staged op}.
  - 5: {count} zero-padded.
  - 6: {busy, done, ovf, 0, PC[3:0] zero-padded}.
  - 7–15: 0.
- Ops (a, b, dest select A=0 .. D=3). All arithmetic is 8-bit modulo 256; carries are discarded.
  - 0 NOP
  - 1 ADD
  - 2 SUB (a−b)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL1 a
  - 7 SHR1 a (logical)
  - 8 MOV a
  - 9 HALT
  - 10–15: NOP (except 10, see Optional Feature)
- Sources are read before writeback, so dest may equal a or b.
- FSM:
  - IDLE: start with count>0 → FETCH, PC=0, busy=1, done=0. Start with count==0 → done=1 on the same edge; busy stays 0.
  - FETCH (1 cycle): latch slot[PC] → EXEC.
  - EXEC (1 cycle): write dest, PC++. HALT or PC+1==count → IDLE with busy=0, done=1 on that edge. Otherwise → FETCH.
- Latency: start written at edge N → busy=1 after N. Instruction i result is visible after edge N+2(i+1). For a k-instruction program, busy=0 and done=1 after edge N+2k.
- done is cleared by a new start or by control bit2.

Optional Feature:
LOOP_EN:
- Defined: op 10 = DJNZ. D <= D−1 (mod 256). If the new D≠0, PC <= {b,a} masked to the PC width; otherwise PC++. A jump target ≥ count ends the run (done=1). DJNZ takes 2 cycles like any other instruction.
- Undefined: op 10 is a NOP.

Test Plan:
- Load A=0x05, B=0x03; program [ADD d=C a=A b=B, SUB d=D a=A b=B]; start → C=0x08, D=0x02, busy high for exactly 4 cycles, then done=1 and uo_out=0x40.
- A=0xFF, B=0x02; program [ADD d=A a=A b=B, SHL1 d=B a=B] → A=0x01 (wrap), B=0x04.
- Load 9 instructions with PROG_DEPTH=8 → count=8, ovf=1. Then control=0x02 → count=0, ovf=0. Start on the empty program → done=1 next cycle, busy never 1.
- During a run, write A=0xAA, write control start, and commit a slot → all three ignored, results unchanged. Program [NOP, HALT, MOV d=A a=B] → halts after 2 instructions, A unchanged.
- Pull rst_n low mid-run at the EXEC cycle → busy=0, done=0, A–D=0 immediately, without waiting for a clock edge.
- LOOP_EN: A=0, B=1, D=3; program [ADD d=A a=A b=B, DJNZ target 0] → A=0x03, D=0x00, done after 12 cycles.
